// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and RUN/HALT/FAULT control
//
// Purpose: holds the PC and presents it to instruction memory. The returned word
// is latched into the IF/ID register together with its PC and PC+4. The fetch
// unit stops when it latches LAST_INSTRUCTION (HALT), or when the PC is
// misaligned or beyond the memory (FAULT).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall_i             hold PC and IF/ID
//   flush_i             turn IF/ID into a NOP bubble
//   redirect_valid_i    load PC from redirect_pc_i (highest priority)
//   redirect_pc_i       redirect target
//   imem_addr_o         byte address to instruction memory (the PC register)
//   imem_rdata_i        instruction word for imem_addr_o, combinational
//   if_instr_o          IF/ID instruction
//   if_pc_o             IF/ID PC
//   if_pc_plus4_o       IF/ID PC+4
//   if_valid_o          IF/ID contents valid
//   halted_o            fetch unit is in HALT
//   fault_o             fetch unit is in FAULT
//   fetch_count_o       number of valid instructions delivered (wraps)

module fetch_stage #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter logic [31:0] LAST_INSTRUCTION = 32'h0000_8067,
  parameter int unsigned IMEM_WORDS       = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o,
  output logic        if_valid_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  // Word-index limit widened so that any IMEM_WORDS up to 2^32 compares correctly.
  localparam logic [32:0] WORD_LIMIT = 33'(IMEM_WORDS);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_plus4;
  logic        r_valid;
  logic        r_halted;
  logic        r_fault;
  logic [31:0] r_count;

  logic [31:0] w_pc_plus4;
  logic        w_legal;
  logic        w_is_last;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_legal    = (r_pc[1:0] == 2'b00) && ({3'b000, r_pc[31:2]} < WORD_LIMIT);
  assign w_is_last  = (imem_rdata_i == LAST_INSTRUCTION);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_if_pc       <= 32'h0;
      r_if_pc_plus4 <= 32'h0;
      r_valid       <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_count       <= 32'h0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (redirect_valid_i) begin
            // Redirect wins over stall; the word at the old PC is discarded.
            r_pc    <= redirect_pc_i;
            r_valid <= 1'b0;
            if (flush_i) begin
              r_instr <= NOP_INSTR;
            end
          end else if (stall_i) begin
            if (flush_i) begin
              r_valid <= 1'b0;
              r_instr <= NOP_INSTR;
            end
          end else if (!w_legal) begin
            // PC stays at the offending address so it can be inspected.
            r_valid <= 1'b0;
            if (flush_i) begin
              r_instr <= NOP_INSTR;
            end
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end else if (flush_i) begin
            // Bubble, but the fetch stream keeps moving.
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= w_pc_plus4;
          end else begin
            r_instr       <= imem_rdata_i;
            r_if_pc       <= r_pc;
            r_if_pc_plus4 <= w_pc_plus4;
            r_valid       <= 1'b1;
            r_count       <= r_count + 32'd1;
            r_pc          <= w_pc_plus4;
            if (w_is_last) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          end
        end
        default: begin
          // HALT and FAULT: PC frozen, redirects ignored, IF/ID drains once
          // downstream consumes it (or it is flushed).
          if (!stall_i || flush_i) begin
            r_valid <= 1'b0;
          end
          if (flush_i) begin
            r_instr <= NOP_INSTR;
          end
        end
      endcase
    end
  end

  assign imem_addr_o   = r_pc;
  assign if_instr_o    = r_instr;
  assign if_pc_o       = r_if_pc;
  assign if_pc_plus4_o = r_if_pc_plus4;
  assign if_valid_o    = r_valid;
  assign halted_o      = r_halted;
  assign fault_o       = r_fault;
  assign fetch_count_o = r_count;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, is the PC value loaded on reset.
REQ-002 Parameter LAST_INSTRUCTION, default 32'h00008067, is the instruction word that ends fetching.
REQ-003 Parameter IMEM_WORDS, default 256, is the instruction memory depth in 32-bit words.
REQ-004 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  is the asynchronous, active-low reset.
REQ-006 stall_i  input  1  holds PC and the IF/ID register.
REQ-007 flush_i  input  1  kills the IF/ID contents (bubble).
REQ-008 redirect_valid_i  input  1  requests a PC redirect (branch/jump resolved downstream).
REQ-009 redirect_pc_i  input  32  is the redirect target.
REQ-010 imem_addr_o  output  32  is the byte address to instruction memory, equal to the current PC, combinational from the PC register.
REQ-011 imem_rdata_i  input  32  is the instruction word returned combinationally for imem_addr_o.
REQ-012 if_instr_o  output  32  is the IF/ID instruction.
REQ-013 if_pc_o  output  32  is the IF/ID PC.
REQ-014 if_pc_plus4_o  output  32  is the IF/ID PC+4.
REQ-015 if_valid_o  output  1  qualifies the IF/ID contents.
REQ-016 halted_o  output  1  is high in HALT.
REQ-017 fault_o  output  1  is high in FAULT.
REQ-018 fetch_count_o  output  32  counts valid instructions delivered.

Function
REQ-019 The FSM shall have states RUN, HALT and FAULT; RUN is the reset state; HALT and FAULT are sticky until reset.
REQ-020 A fetch is legal when PC[1:0]==0 and PC[31:2] < IMEM_WORDS.
REQ-021 In RUN with a legal fetch, stall_i=0 and no redirect, each edge shall load IF/ID with {imem_rdata_i, PC, PC+4, valid=1} and set PC to PC+4, giving one-cycle latency from PC to IF/ID.
REQ-022 Priority shall be redirect > stall > sequential.
REQ-023 With redirect_valid_i=1 in RUN, PC shall load redirect_pc_i regardless of stall_i, and IF/ID valid shall go to 0 on the same edge.
REQ-024 With stall_i=1, flush_i=0 and no redirect, PC and all IF/ID fields shall hold.
REQ-025 With flush_i=1, IF/ID valid shall go to 0 and if_instr_o to 32'h00000013 (NOP), regardless of stall_i.
REQ-026 With flush_i=1, stall_i=0 and no redirect, PC shall still advance; with flush_i=1 and stall_i=1, PC shall hold.
REQ-027 When a legal sequential fetch in RUN latches an instruction equal to LAST_INSTRUCTION, that instruction shall be delivered with valid=1 and the FSM shall enter HALT on the same edge.
REQ-028 In HALT, PC shall hold and redirects shall be ignored.
REQ-029 In HALT, IF/ID valid shall clear on the first edge with stall_i=0 or flush_i=1, and IF/ID shall load nothing new.
REQ-030 In RUN without redirect and without stall, an illegal fetch shall latch nothing, set IF/ID valid to 0, leave PC holding the offending address and enter FAULT.
REQ-031 In FAULT, PC and IF/ID shall behave as in HALT.
REQ-032 A redirect to an illegal target shall be accepted; the fault is raised on the following non-stalled cycle.
REQ-033 fetch_count_o shall increment by 1 on each edge that loads IF/ID with valid=1, and shall wrap from 2^32-1 to 0.
REQ-034 PC+4 shall be computed modulo 2^32.

Reset
REQ-035 While rst_n=0: PC=RESET_PC, if_instr_o=32'h00000013, if_pc_o=0, if_pc_plus4_o=0, if_valid_o=0, fetch_count_o=0, state=RUN, halted_o=0, fault_o=0.
REQ-036 Reset asserted mid-operation, including in HALT or FAULT, shall take effect immediately, without waiting for a clock edge.
REQ-037 The first fetch after reset release shall use RESET_PC.

Verification
REQ-038 Reset release, memory word0..3 = 0x00500093, 0x00100113, 0x002081B3, 0x00008067 -> IF/ID PCs 0, 4, 8, 0xC on consecutive cycles, all valid; halted_o=1 after the 4th; fetch_count_o=4; PC held at 0x10.
REQ-039 stall_i high for 3 cycles at PC=8 -> if_pc_o stays 4 and imem_addr_o stays 8; on release, PC 8 is delivered next.
REQ-040 redirect_valid_i=1 with redirect_pc_i=0x40 and stall_i=1 -> next cycle imem_addr_o=0x40 and if_valid_o=0; the following cycle if_pc_o=0x40 with valid=1.
REQ-041 Redirect to 0x402 -> fault_o=1 one non-stalled cycle later, imem_addr_o=0x402, if_valid_o=0, fetch_count_o frozen; sequential run to PC=0x400 (IMEM_WORDS=256) -> fault_o=1.
REQ-042 flush_i=1 with stall_i=0 -> bubble (valid=0, instr 0x13) and PC advances by 4; rst_n pulse low while in HALT -> all outputs at reset values immediately.
